// File: rtl/dino_pkg.sv
// Shared definitions for the dino game: FSM state encoding, lane width and
// the default jump/score sizing used by the obstacle generator and top level.
package dino_pkg;

  localparam int LANE_W             = 8;
  localparam int DEFAULT_JUMP_STEPS = 3;
  localparam int DEFAULT_SCORE_W    = 16;

  // Airborne step counter width; covers JUMP_STEPS up to 15.
  localparam int AIR_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    AIR  = 2'd2,
    OVER = 2'd3
  } state_t;

  // True when the lane cell under the dino holds an obstacle.
  function automatic logic lane_hit(input logic [LANE_W-1:0] line, input int pos);
    return line[pos];
  endfunction

endpackage

// File: rtl/dino_collision_ctrl_if.sv
// Obstacle lane link between obstacle_generator (master) and the collision
// controller (slave).
//
// Handshake: step is a one-cycle valid strobe with no ready/back-pressure;
// ledLine is valid in every cycle step is high and the slave must consume it
// in that cycle. Consecutive step pulses are legal. gen_reset flows the other
// way as a one-cycle restart request that the master must accept immediately.
interface dino_collision_ctrl_if;
  import dino_pkg::*;

  logic              step;
  logic [LANE_W-1:0] ledLine;
  logic              gen_reset;

  modport master (output step, output ledLine, input gen_reset);
  modport slave  (input step, input ledLine, output gen_reset);

endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous level input followed by a
// registered rising-edge detector. Input rise to rise pulse is 3 clk;
// a held input produces exactly one pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;

  // Synchronize, remember the previous synchronized level, register the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/dino_collision_ctrl.sv
// Consumer end of the obstacle lane: tracks the dino jump state, detects
// collisions, keeps the score and requests generator restarts.
// Optional macro DINO_HISCORE_EN adds a high_score output kept across games.
module dino_collision_ctrl
  import dino_pkg::*;
#(
  parameter int DINO_POS   = 0,
  parameter int JUMP_STEPS = DEFAULT_JUMP_STEPS,
  parameter int SCORE_W    = DEFAULT_SCORE_W
) (
  input  logic                 clk,
  input  logic                 reset,
  dino_collision_ctrl_if.slave lane,
  input  logic                 jump_btn,
  output logic                 dino_air,
  output logic                 collision,
  output logic                 game_over,
  output logic [SCORE_W-1:0]   score,
`ifdef DINO_HISCORE_EN
  output logic [SCORE_W-1:0]   high_score,
`endif
  output state_t               state_dbg
);

  state_t             state_q, state_n;
  logic [SCORE_W-1:0] score_q, score_n;
  logic [AIR_W-1:0]   air_cnt_q, air_cnt_n;
  logic               collision_q, collision_n;
  logic               jump_evt;
  logic               hit;
  logic               unused_lane;

  btn_sync_edge u_btn (
    .clk   (clk),
    .reset (reset),
    .in    (jump_btn),
    .rise  (jump_evt)
  );

  assign hit         = lane_hit(lane.ledLine, DINO_POS);
  assign unused_lane = ^lane.ledLine;

  // Next-state, score, jump counter and collision decode for the game FSM.
  always_comb begin
    state_n        = state_q;
    score_n        = score_q;
    air_cnt_n      = air_cnt_q;
    collision_n    = 1'b0;
    lane.gen_reset = 1'b0;
    case (state_q)
      IDLE: begin
        if (jump_evt) begin
          state_n        = RUN;
          score_n        = '0;
          lane.gen_reset = 1'b1;
        end
      end
      RUN: begin
        // An obstacle arriving on the ground beats a jump in the same cycle.
        if (lane.step && hit) begin
          state_n     = OVER;
          collision_n = 1'b1;
        end else if (jump_evt) begin
          state_n   = AIR;
          air_cnt_n = AIR_W'(JUMP_STEPS);
        end
      end
      AIR: begin
        if (lane.step) begin
          if (hit && (score_q != {SCORE_W{1'b1}})) begin
            score_n = score_q + 1'b1;
          end
          // The landing step is still scored as airborne above.
          if (air_cnt_q == AIR_W'(1)) begin
            state_n   = RUN;
            air_cnt_n = '0;
          end else begin
            air_cnt_n = air_cnt_q - 1'b1;
          end
        end
      end
      OVER: begin
        if (jump_evt) begin
          state_n        = RUN;
          score_n        = '0;
          lane.gen_reset = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Game state, score, jump counter and collision pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      score_q     <= '0;
      air_cnt_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      score_q     <= score_n;
      air_cnt_q   <= air_cnt_n;
      collision_q <= collision_n;
    end
  end

`ifdef DINO_HISCORE_EN
  logic [SCORE_W-1:0] high_score_q;

  // Capture the best score as a game ends; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      high_score_q <= '0;
    end else if (collision_n && (score_q > high_score_q)) begin
      high_score_q <= score_q;
    end
  end

  assign high_score = high_score_q;
`endif

  assign dino_air  = (state_q == AIR);
  assign game_over = (state_q == OVER);
  assign collision = collision_q;
  assign score     = score_q;
  assign state_dbg = state_q;

endmodule

// File: doc/dino_collision_ctrl.md
Name: dino_collision_ctrl

Overview:
- Consumer end of the obstacle lane.
- Samples the 8-bit `ledLine` driven by `obstacle_generator` each time the lane advances.
- Tracks the dino's jump state from the player button, detects collisions and keeps the score.
- Drives a one-cycle restart request back to the generator when a new game begins.
- Sits between `obstacle_generator` and the display/score logic in the game top level.

Parameters:
- DINO_POS, 0, bit index of `ledLine` occupied by the dino (0..7).
- JUMP_STEPS, 3, number of lane steps the dino stays airborne per jump (1..15).
- SCORE_W, 16, width of the score counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- step  input  1  one-cycle pulse; `ledLine` already holds the newly shifted pattern in this cycle.
- ledLine  input  8  obstacle pattern from `obstacle_generator`; bit=1 means obstacle present.
- jump_btn  input  1  raw player button, level, asynchronous to clk.
- gen_reset  output  1  one-cycle pulse requesting the obstacle generator to restart.
- dino_air  output  1  1 while the dino is airborne.
- collision  output  1  one-cycle pulse on the collision cycle.
- game_over  output  1  level; 1 while in OVER.
- score  output  SCORE_W  obstacles cleared this game.

Behaviour:
- Reset: clk and reset only; reset is synchronous and active-high.
  - state=IDLE, score=0, air_cnt=0.
  - gen_reset, dino_air, collision, game_over all 0.
  - Button synchronizer flops cleared.
  - Reset mid-game aborts immediately on the next edge; no pulses are emitted.
- Button path: 2-flop synchronizer, then a rising-edge detector producing `jump_evt`.
  - Total latency: button rise to `jump_evt` = 3 clk.
  - A held button gives exactly one event.
- FSM states: IDLE, RUN, AIR, OVER. All transitions take effect on the next clk edge.
  - IDLE:
    - `step` is ignored.
    - `jump_evt` -> RUN; gen_reset=1 for that one cycle; score cleared.
  - RUN:
    - If `step` && ledLine[DINO_POS]: -> OVER; collision=1 for one cycle; game_over=1 from the next cycle.
    - Else if `jump_evt`: -> AIR; air_cnt=JUMP_STEPS.
    - If `step` with an obstacle and `jump_evt` occur in the same cycle, the collision wins (strict timing).
  - AIR: dino_air=1.
    - On `step`: if ledLine[DINO_POS], score+1, saturating at all-ones.
    - On `step`: air_cnt decrements. When air_cnt==1 at a step, the next state is RUN.
    - The landing step itself is still scored as airborne.
    - `jump_evt` is ignored; no double jump.
    - A collision cannot occur in AIR.
  - OVER:
    - score and game_over are held.
    - `step` is ignored.
    - `jump_evt` -> RUN; score=0; gen_reset pulse.
- Outputs are registered. dino_air and game_over are decoded from registered state, so they carry no combinational path from inputs.
- `step` pulses arriving on consecutive cycles are each handled; there is no minimum spacing.

Optional Feature:
- Macro: DINO_HISCORE_EN.
- Defined:
  - Adds output port `high_score` [SCORE_W-1:0].
  - `high_score` is updated on the cycle entering OVER when score > high_score.
  - It is cleared only by `reset`, not by a new game.
- Undefined:
  - No `high_score` port and no register.
  - All other behaviour is identical.

Decomposition:
- Package `dino_pkg`:
  - state enum (IDLE, RUN, AIR, OVER).
  - LANE_W=8.
  - Default JUMP_STEPS and SCORE_W constants, shared with `obstacle_generator` and the top level.
- One sub-module: `btn_sync_edge` (2-flop synchronizer plus rising-edge detect, ports clk/reset/in/rise), reusable for other buttons.

Test Plan:
- Reset held for 2 cycles with step=1 and ledLine=8'hFF -> all outputs 0, state IDLE; release with no button -> stays IDLE, no gen_reset.
- Button press in IDLE -> gen_reset high for exactly 1 cycle, 3 clk after press; `step` with ledLine=8'h01 (DINO_POS=0) while grounded -> collision pulse 1 cycle, game_over=1, score=0.
- In RUN, press jump, then 3 steps with ledLine=8'h01, 8'h00, 8'h01 -> dino_air=1 throughout, score=2; 4th step with 8'h01 -> collision (dino has landed).
- Jump event in the same cycle as step with 8'h01 in RUN -> collision (strict priority); button held 20 cycles in AIR -> single jump only.
- Preload score to 16'hFFFF (force), clear another obstacle -> score stays 16'hFFFF; press in OVER -> score=0, gen_reset pulse, state RUN.
- With DINO_HISCORE_EN: game 1 ends at score 5, game 2 ends at 3 -> high_score=5; after reset -> 0.
